alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
// Multi-cycle control FSM for the ROM + ALU datapath, sitting between the program ROM and the ALU under main.
// - Owns the program counter and fetches 19-bit instruction words {op[18:16], A[15:8], B[7:0]}.
// - Issues each instruction to the ALU with a start/done handshake and latches the result.
// - Runs continuously (m=1) or one instruction per step pulse (m=0).
// - Supports a halt instruction and an ALU timeout.
// PARAMETERS
// ADDR_W     5          ROM address width
// LAST_ADDR  31         highest program address; PC wraps to 0 after it
// HALT_WORD  19'h7FFFF  instruction word decoded as HALT
// TIMEOUT    15         max cycles spent in WAIT_ALU before error
// PORTS
// clk          in   1       system clock, all logic on posedge
// reset        in   1       synchronous, active-high
// m            in   1       mode: 1 = continuous run, 0 = single step
// step         in   1       advance one instruction (m=0 only), level sampled in IDLE
// rom_en       out  1       ROM read strobe
// rom_addr     out  ADDR_W  ROM address (= PC)
// rom_data     in   19      ROM word, valid the cycle after rom_en
// alu_op       out  3       ALU opcode
// alu_a        out  8       ALU operand A
// alu_b        out  8       ALU operand B
// alu_start    out  1       one-cycle ALU launch pulse
// alu_res      in   8       ALU result, valid while alu_done=1
// alu_done     in   1       ALU completion
// instruccion  out  19      currently latched instruction word
// resultado    out  8       last captured ALU result
// res_valid    out  1       one-cycle pulse: resultado updated
// busy         out  1       1 in any state other than IDLE/HALT
// halted       out  1       sticky; HALT state reached
// err          out  1       sticky; ALU timeout occurred
// instr_count  out  16      retired instructions, wraps at 2^16
// BEHAVIOUR
// - Reset (sync, any state): state=IDLE, PC=0, all outputs 0, timeout counter 0.
// - States: IDLE, FETCH, WAIT_ROM, EXEC, WAIT_ALU, WRITE, HALT.
//   - IDLE: go to FETCH if m=1, or if m=0 and step=1; otherwise stay.
//   - FETCH: rom_en=1, rom_addr=PC (one cycle) -> WAIT_ROM.
//   - WAIT_ROM: instruccion<=rom_data -> EXEC.
//   - EXEC, instruccion==HALT_WORD: no alu_start; halted<=1 -> HALT; PC unchanged.
//   - EXEC, otherwise: drive alu_op/a/b from instruccion, alu_start=1 for exactly this cycle -> WAIT_ALU.
//     alu_op/a/b hold until the next EXEC.
//   - WAIT_ALU: alu_done=1 -> resultado<=alu_res, res_valid<=1, -> WRITE.
//     Else the counter increments; counter==TIMEOUT -> err<=1, halted<=1 -> HALT.
//   - WRITE: res_valid high this cycle only.
//     PC <= (PC==LAST_ADDR) ? 0 : PC+1; instr_count+1.
//     m sampled here: 1 -> FETCH, 0 -> IDLE.
//   - HALT: terminal; m, step and alu_done ignored; exit only by reset.
// - Latency: with alu_done one cycle after alu_start, 5 cycles per instruction (FETCH..WRITE).
//   alu_done in the same cycle as alu_start is not seen.
// - alu_done outside WAIT_ALU is ignored. step while busy is ignored, not queued.
// - m changes mid-instruction take effect only at WRITE.
// - The timeout counter clears on entry to WAIT_ALU.
// - Reset during WAIT_ALU: a late alu_done arrives in IDLE and is ignored.
// TESTING
// 1 reset=1 for 2 cycles, m=1 -> outputs all 0; first cycle after release rom_en=1, rom_addr=0.
// 2 Run: ROM[0]=19'h10503, ALU done 1 cycle after start, res=8'h08
//   -> alu_op=001, alu_a=05, alu_b=03, alu_start 1 cycle; resultado=08 with 1-cycle res_valid; rom_addr=1 five cycles after first fetch.
// 3 Wrap: 32 non-halt words, m=1 -> after addr 31 next rom_addr=0, instr_count=32.
// 4 Step: m=0, step pulses at T and T+2 -> exactly one instruction retires, PC=1, then IDLE.
// 5 Halt: ROM[2]=19'h7FFFF -> no alu_start for it; halted=1, busy=0, rom_addr stays 2; step/m ignored until reset.
// 6 Timeout: ALU never asserts done -> err=1, halted=1 after 15 cycles in WAIT_ALU; mid-WAIT_ALU reset clears both.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// ROM fetch and ALU launch/complete signals between the sequencer (master) and the datapath (slave).
interface alu_sequencer_if #(
   parameter int ADDR_W = 5
);
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [18:0]       rom_data;
   logic [2:0]        alu_op;
   logic [7:0]        alu_a;
   logic [7:0]        alu_b;
   logic              alu_start;
   logic [7:0]        alu_res;
   logic              alu_done;

   modport master (
      output rom_en, rom_addr, alu_op, alu_a, alu_b, alu_start,
      input  rom_data, alu_res, alu_done
   );

   modport slave (
      input  rom_en, rom_addr, alu_op, alu_a, alu_b, alu_start,
      output rom_data, alu_res, alu_done
   );
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/issue/retire FSM for the ROM + ALU datapath: 5 cycles per instruction with a 1-cycle ALU.
// Runs continuously or single-step; HALT word and ALU timeout both park the FSM until reset.
module alu_sequencer #(
   parameter int                ADDR_W    = 5,
   parameter logic [ADDR_W-1:0] LAST_ADDR = 5'd31,
   parameter logic [18:0]       HALT_WORD = 19'h7FFFF,
   parameter int                TIMEOUT   = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m,
   input  logic        step,
   alu_sequencer_if.master bus,
   output logic [18:0] instruccion,
   output logic [7:0]  resultado,
   output logic        res_valid,
   output logic        busy,
   output logic        halted,
   output logic        err,
   output logic [15:0] instr_count
);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] FETCH    = 3'd1;
   localparam logic [2:0] WAIT_ROM = 3'd2;
   localparam logic [2:0] EXEC     = 3'd3;
   localparam logic [2:0] WAIT_ALU = 3'd4;
   localparam logic [2:0] WRITE    = 3'd5;
   localparam logic [2:0] HALT     = 3'd6;

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [2:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [CNT_W-1:0]  tcnt;
   logic [CNT_W-1:0]  tcnt_nxt;
   logic [2:0]        op_q;
   logic [7:0]        a_q;
   logic [7:0]        b_q;
   logic              is_halt;

   assign is_halt  = (instruccion == HALT_WORD);
   assign tcnt_nxt = tcnt + 1'b1;

   assign bus.rom_en    = (state == FETCH);
   assign bus.rom_addr  = pc;
   assign bus.alu_start = (state == EXEC) && !is_halt;
   // Operands come straight from the instruction during the launch cycle, then hold.
   assign bus.alu_op    = bus.alu_start ? instruccion[18:16] : op_q;
   assign bus.alu_a     = bus.alu_start ? instruccion[15:8]  : a_q;
   assign bus.alu_b     = bus.alu_start ? instruccion[7:0]   : b_q;
   assign busy          = (state != IDLE) && (state != HALT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= '0;
         tcnt        <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         instruccion <= '0;
         resultado   <= '0;
         res_valid   <= 1'b0;
         halted      <= 1'b0;
         err         <= 1'b0;
         instr_count <= '0;
      end else begin
         res_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (m || step) state <= FETCH;
            end
            FETCH: begin
               state <= WAIT_ROM;
            end
            WAIT_ROM: begin
               instruccion <= bus.rom_data;
               state       <= EXEC;
            end
            EXEC: begin
               if (is_halt) begin
                  halted <= 1'b1;
                  state  <= HALT;
               end else begin
                  op_q  <= instruccion[18:16];
                  a_q   <= instruccion[15:8];
                  b_q   <= instruccion[7:0];
                  tcnt  <= '0;
                  state <= WAIT_ALU;
               end
            end
            WAIT_ALU: begin
               if (bus.alu_done) begin
                  resultado <= bus.alu_res;
                  res_valid <= 1'b1;
                  state     <= WRITE;
               end else begin
                  tcnt <= tcnt_nxt;
                  if (tcnt_nxt == CNT_W'(TIMEOUT)) begin
                     err    <= 1'b1;
                     halted <= 1'b1;
                     state  <= HALT;
                  end
               end
            end
            WRITE: begin
               pc          <= (pc == LAST_ADDR) ? '0 : pc + 1'b1;
               instr_count <= instr_count + 16'd1;
               state       <= m ? FETCH : IDLE;
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
